// File: rtl/conway_board_driver.sv
// rtl/conway_board_driver.sv - serial pattern loader, commit strobe and generation stepper for a Conway grid
module conway_board_driver #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TICK_DIV = 4,
  parameter int GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  input  logic                 run_en,
  output logic [ROWS*COLS-1:0] state_0,
  output logic                 grid_rst,
  output logic                 grid_ena,
  output logic                 loaded,
  output logic [GEN_W-1:0]     generation
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TCK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [TCK_W-1:0] LAST_TICK = TCK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, RUN} state_t;

  state_t           st;
  logic [IDX_W-1:0] index;
  logic [TCK_W-1:0] tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      index      <= '0;
      tick       <= '0;
      state_0    <= '0;
      generation <= '0;
      in_ready   <= 1'b0;
      grid_rst   <= 1'b0;
      grid_ena   <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      // Both grid strobes are single-cycle pulses; they are only ever set by one state at a time.
      grid_rst <= 1'b0;
      grid_ena <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            st       <= LOAD;
            index    <= '0;
            state_0  <= '0;
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (start) begin
            index   <= '0;
            state_0 <= '0;
          end else if (in_valid && in_ready) begin
            state_0[index] <= in_bit;
            if (index == LAST_IDX) begin
              st       <= COMMIT;
              in_ready <= 1'b0;
              grid_rst <= 1'b1;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        COMMIT: begin
          st         <= RUN;
          loaded     <= 1'b1;
          generation <= '0;
          tick       <= '0;
        end
        RUN: begin
          // generation is left alone on restart so it still reads the last run until the next commit.
          if (start) begin
            st       <= LOAD;
            loaded   <= 1'b0;
            index    <= '0;
            state_0  <= '0;
            in_ready <= 1'b1;
          end else if (run_en) begin
            if (tick == LAST_TICK) begin
              tick       <= '0;
              grid_ena   <= 1'b1;
              generation <= generation + 1'b1;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
